// File: rtl/reset_request_gen.sv
// Merges a debounced push-button, a software pulse and a watchdog into one start pulse
// for the reset boot sequencer, then tracks the sequencer's reset output through a holdoff.
module reset_request_gen #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int WDT_LIMIT       = 1000000,
  parameter int ACK_TIMEOUT     = 16,
  parameter int HOLDOFF_CYCLES  = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_i,
  input  logic       sw_req_i,
  input  logic       wdt_en_i,
  input  logic       wdt_kick_i,
  input  logic       reset_active_i,
  output logic       start_o,
  output logic       busy_o,
  output logic [1:0] cause_o,
  output logic       ack_err_o,
  output logic [7:0] req_count_o
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int WD_W = $clog2(WDT_LIMIT + 1);
  localparam int T_MAX = (ACK_TIMEOUT > HOLDOFF_CYCLES) ? ACK_TIMEOUT : HOLDOFF_CYCLES;
  localparam int T_W = $clog2(T_MAX + 1);

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_LAST   = WD_W'(WDT_LIMIT - 1);
  localparam logic [T_W-1:0]  ACK_LAST  = T_W'(ACK_TIMEOUT - 1);
  localparam logic [T_W-1:0]  HOLD_LAST = T_W'(HOLDOFF_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ASSERT,
    WAIT_RELEASE,
    HOLDOFF
  } state_t;

  state_t           state;
  logic             btn_p0;
  logic             btn_p1;
  logic             btn_level;
  logic [DB_W-1:0]  db_cnt;
  logic             btn_req;
  logic [WD_W-1:0]  wd_cnt;
  logic             wdt_req;
  logic [T_W-1:0]   tcnt;
  logic             any_req;

  // Button beats software, software beats watchdog.
  function automatic logic [1:0] pick_cause(input logic btn, input logic sw);
    if (btn) return 2'b01;
    if (sw)  return 2'b10;
    return 2'b11;
  endfunction

  assign any_req = btn_req | sw_req_i | wdt_req;

  // Stage p0/p1: two-flop synchronizer, then debounce into btn_level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_p0    <= 1'b0;
      btn_p1    <= 1'b0;
      btn_level <= 1'b0;
      db_cnt    <= '0;
      btn_req   <= 1'b0;
    end else begin
      btn_p0  <= btn_i;
      btn_p1  <= btn_p0;
      btn_req <= 1'b0;
      if (btn_p1 == btn_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt    <= '0;
        btn_level <= btn_p1;
        btn_req   <= btn_p1;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt  <= '0;
      wdt_req <= 1'b0;
    end else begin
      wdt_req <= 1'b0;
      if (!wdt_en_i || wdt_kick_i || (state != IDLE)) begin
        wd_cnt <= '0;
      end else if (wd_cnt == WD_LAST) begin
        wd_cnt  <= '0;
        wdt_req <= 1'b1;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end

  // Requests are only looked at in IDLE; anything arriving elsewhere is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      start_o     <= 1'b0;
      busy_o      <= 1'b0;
      cause_o     <= 2'b00;
      ack_err_o   <= 1'b0;
      req_count_o <= 8'd0;
      tcnt        <= '0;
    end else begin
      start_o <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state       <= ISSUE;
            start_o     <= 1'b1;
            busy_o      <= 1'b1;
            cause_o     <= pick_cause(btn_req, sw_req_i);
            req_count_o <= req_count_o + 8'd1;
          end
        end
        ISSUE: begin
          state <= WAIT_ASSERT;
          tcnt  <= '0;
        end
        WAIT_ASSERT: begin
          if (reset_active_i) begin
            state <= WAIT_RELEASE;
          end else if (tcnt == ACK_LAST) begin
            ack_err_o <= 1'b1;
            state     <= HOLDOFF;
            tcnt      <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        WAIT_RELEASE: begin
          if (!reset_active_i) begin
            state <= HOLDOFF;
            tcnt  <= '0;
          end
        end
        HOLDOFF: begin
          if (tcnt == HOLD_LAST) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_request_gen.sv
// Directed bench for reset_request_gen with a behavioural sequencer and a start-pulse scoreboard.
module tb_reset_request_gen;

  localparam int DEB  = 4;
  localparam int WDL  = 20;
  localparam int ACKT = 16;
  localparam int HOLD = 8;
  // Busy span of a normal sequence: ISSUE + 2 waiting for ack + 20 active + holdoff.
  localparam int SEQ_BUSY = 1 + 2 + 20 + HOLD;

  logic       clk;
  logic       rst_n;
  logic       btn_i;
  logic       sw_req_i;
  logic       wdt_en_i;
  logic       wdt_kick_i;
  logic       reset_active_i;
  logic       start_o;
  logic       busy_o;
  logic [1:0] cause_o;
  logic       ack_err_o;
  logic [7:0] req_count_o;

  int compared   = 0;
  int mismatched = 0;
  int n_starts   = 0;
  int n;
  int lat;
  int sb;

  logic [9:0] exp_q[$];
  logic [9:0] exp_e;
  logic [7:0] exp_count;

  logic       model_en;
  logic [4:0] seq_t;

  reset_request_gen #(
    .DEBOUNCE_CYCLES(DEB),
    .WDT_LIMIT(WDL),
    .ACK_TIMEOUT(ACKT),
    .HOLDOFF_CYCLES(HOLD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_i(btn_i),
    .sw_req_i(sw_req_i),
    .wdt_en_i(wdt_en_i),
    .wdt_kick_i(wdt_kick_i),
    .reset_active_i(reset_active_i),
    .start_o(start_o),
    .busy_o(busy_o),
    .cause_o(cause_o),
    .ack_err_o(ack_err_o),
    .req_count_o(req_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sequencer model: reset active from 2 cycles after the start pulse, for 20 cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) seq_t <= 5'd0;
    else if (model_en && start_o) seq_t <= 5'd1;
    else if (seq_t != 5'd0 && seq_t < 5'd21) seq_t <= seq_t + 5'd1;
    else seq_t <= 5'd0;
  end
  assign reset_active_i = model_en && (seq_t >= 5'd2);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_start(input logic [1:0] c);
    exp_count = exp_count + 8'd1;
    exp_q.push_back({c, exp_count});
  endtask

  task automatic wait_start(input int limit, output int l);
    l = 0;
    do begin
      @(negedge clk);
      l++;
    end while (start_o !== 1'b1 && l < limit);
    if (start_o !== 1'b1) l = -1;
  endtask

  task automatic wait_idle(input int limit, output int cnt);
    cnt = 0;
    while (busy_o === 1'b1 && cnt < limit) begin
      @(negedge clk);
      cnt++;
    end
    check("idle_reached", 32'(busy_o), 32'd0);
  endtask

  // Scoreboard: every start pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && start_o) begin
      n_starts++;
      if (exp_q.size() == 0) begin
        check("unexpected_start", 32'(start_o), 32'd0);
      end else begin
        exp_e = exp_q.pop_front();
        check("start_cause_count", 32'({cause_o, req_count_o}), 32'(exp_e));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n      = 1'b0;
    btn_i      = 1'b0;
    sw_req_i   = 1'b0;
    wdt_en_i   = 1'b0;
    wdt_kick_i = 1'b0;
    model_en   = 1'b1;
    exp_count  = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_start", 32'(start_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_cause", 32'(cause_o), 32'd0);
    check("rst_ack_err", 32'(ack_err_o), 32'd0);
    check("rst_count", 32'(req_count_o), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Software request: start exactly the next cycle, one cycle wide.
    sw_req_i = 1'b1;
    expect_start(2'b10);
    @(negedge clk);
    sw_req_i = 1'b0;
    check("t1_start", 32'(start_o), 32'd1);
    check("t1_busy", 32'(busy_o), 32'd1);
    check("t1_cause", 32'(cause_o), 32'd2);
    check("t1_count", 32'(req_count_o), 32'd1);
    @(negedge clk);
    check("t1_start_width", 32'(start_o), 32'd0);
    wait_idle(80, n);
    check("t1_busy_len", 32'(n), 32'(SEQ_BUSY - 1));

    // Bouncing button, then stable high.
    sb = n_starts;
    for (int i = 0; i < 16; i++) begin
      btn_i = (i % 2 == 0);
      repeat (2) @(negedge clk);
    end
    check("t2_no_start_bounce", 32'(n_starts), 32'(sb));
    btn_i = 1'b1;
    expect_start(2'b01);
    wait_start(30, lat);
    check("t2_btn_latency", 32'(lat), 32'(2 + DEB + 1));
    check("t2_cause", 32'(cause_o), 32'd1);
    wait_idle(80, n);
    btn_i = 1'b0;
    repeat (20) @(negedge clk);
    check("t2_release_no_start", 32'(n_starts), 32'(sb + 1));

    // Watchdog expiry, then kicked watchdog.
    wdt_en_i = 1'b1;
    expect_start(2'b11);
    wait_start(40, lat);
    wdt_en_i = 1'b0;
    check("t3_wdt_latency", 32'(lat), 32'(WDL + 1));
    check("t3_cause", 32'(cause_o), 32'd3);
    wait_idle(80, n);
    sb = n_starts;
    wdt_en_i = 1'b1;
    for (int i = 0; i < 200; i++) begin
      wdt_kick_i = (i % 15 == 14);
      @(negedge clk);
    end
    wdt_kick_i = 1'b0;
    wdt_en_i   = 1'b0;
    check("t3_kicked_no_start", 32'(n_starts), 32'(sb));

    // Button and software on the same edge; later software pulses are dropped.
    sb = n_starts;
    btn_i = 1'b1;
    repeat (6) @(negedge clk);
    sw_req_i = 1'b1;
    expect_start(2'b01);
    @(negedge clk);
    sw_req_i = 1'b0;
    check("t4_start", 32'(start_o), 32'd1);
    check("t4_cause", 32'(cause_o), 32'd1);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 10) check("t4_busy_wait_release", 32'(busy_o), 32'd1);
      if (k == 30) check("t4_busy_last_holdoff", 32'(busy_o), 32'd1);
      if (k == 31) check("t4_idle_after_holdoff", 32'(busy_o), 32'd0);
      sw_req_i = (k == 9 || k == 25 || k == 30);
    end
    sw_req_i = 1'b0;
    repeat (10) @(negedge clk);
    check("t4_one_start", 32'(n_starts), 32'(sb + 1));
    btn_i = 1'b0;
    repeat (15) @(negedge clk);

    // Sequencer never acknowledges.
    model_en = 1'b0;
    sw_req_i = 1'b1;
    expect_start(2'b10);
    @(negedge clk);
    sw_req_i = 1'b0;
    check("t5_start", 32'(start_o), 32'd1);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 16) check("t5_ack_err_before", 32'(ack_err_o), 32'd0);
      if (k == 17) check("t5_ack_err_set", 32'(ack_err_o), 32'd1);
      if (k == 24) check("t5_busy_holdoff", 32'(busy_o), 32'd1);
      if (k == 25) check("t5_idle", 32'(busy_o), 32'd0);
    end
    model_en = 1'b1;
    sw_req_i = 1'b1;
    expect_start(2'b10);
    @(negedge clk);
    sw_req_i = 1'b0;
    wait_idle(80, n);
    check("t5_ack_err_sticky", 32'(ack_err_o), 32'd1);

    // Reset in the middle of WAIT_RELEASE.
    sw_req_i = 1'b1;
    expect_start(2'b10);
    @(negedge clk);
    sw_req_i = 1'b0;
    repeat (10) @(negedge clk);
    check("t6_busy_pre_reset", 32'(busy_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_start", 32'(start_o), 32'd0);
    check("t6_rst_busy", 32'(busy_o), 32'd0);
    check("t6_rst_cause", 32'(cause_o), 32'd0);
    check("t6_rst_ack_err", 32'(ack_err_o), 32'd0);
    check("t6_rst_count", 32'(req_count_o), 32'd0);
    exp_count = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
    sb = n_starts;
    repeat (30) @(negedge clk);
    check("t6_no_start_after_release", 32'(n_starts), 32'(sb));
    check("t6_idle_after_release", 32'(busy_o), 32'd0);

    // 256 requests wrap the counter.
    for (int i = 0; i < 256; i++) begin
      sw_req_i = 1'b1;
      expect_start(2'b10);
      @(negedge clk);
      sw_req_i = 1'b0;
      check("t6_wrap_start", 32'(start_o), 32'd1);
      wait_idle(80, n);
    end
    check("t6_count_wrapped", 32'(req_count_o), 32'd0);
    check("t6_starts_total", 32'(n_starts), 32'(sb + 256));
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/reset_request_gen.md
Name: reset_request_gen

Overview:
Upstream request stage for the processor reset boot sequencer. It merges three reset sources into one single-cycle start pulse for the sequencer:
- a bouncy external push-button
- a software/controller command pulse
- an internal watchdog

It tracks the sequencer's reset output to enforce one request per sequence plus a holdoff. It records the cause of the last reset for the controller.

Parameters:
DEBOUNCE_CYCLES, 1000, consecutive stable cycles required before debounced button level changes (>=2)
WDT_LIMIT, 1000000, enabled un-kicked cycles before watchdog request (>=2)
ACK_TIMEOUT, 16, cycles to wait for sequencer to assert reset after start pulse
HOLDOFF_CYCLES, 64, cycles after reset release during which new requests are discarded

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
btn_i  input  1  raw push-button, active-high, asynchronous to clk
sw_req_i  input  1  software reset request, one-cycle pulse, synchronous
wdt_en_i  input  1  watchdog enable level
wdt_kick_i  input  1  watchdog kick pulse
reset_active_i  input  1  sequencer's active-high reset output (feedback)
start_o  output  1  one-cycle start pulse to sequencer
busy_o  output  1  high in any state other than IDLE
cause_o  output  2  last issued cause: 00 none, 01 button, 10 software, 11 watchdog
ack_err_o  output  1  sticky: sequencer failed to acknowledge within ACK_TIMEOUT
req_count_o  output  8  number of issued start pulses, wraps 255->0

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE; start_o=0, busy_o=0, cause_o=00, ack_err_o=0, req_count_o=0.
  - Synchronizer, debounced level, debounce and watchdog counters all =0.
- Button path:
  - 2-FF synchronizer on btn_i.
  - Debounce counter resets whenever synced value equals debounced level.
  - Otherwise it increments; on reaching DEBOUNCE_CYCLES, debounced level takes the synced value and the counter clears.
  - A 0->1 transition of the debounced level is a one-cycle btn_req. A 1->0 transition generates nothing.
  - The debounce logic runs in all states.
- Watchdog:
  - Counter clears when wdt_en_i=0, when wdt_kick_i=1, or when state!=IDLE.
  - Otherwise it increments.
  - When the counter equals WDT_LIMIT-1, it raises wdt_req for one cycle and clears.
  - Counter width is sufficient for WDT_LIMIT with no overflow.
- Priority for simultaneous requests in IDLE: button > software > watchdog. Exactly one cause is latched.
- FSM:
  - IDLE: any request -> ISSUE; latch cause into cause_o.
  - ISSUE: start_o=1 for exactly this one cycle; req_count_o increments; timeout counter cleared -> WAIT_ASSERT.
  - WAIT_ASSERT:
    - reset_active_i=1 -> WAIT_RELEASE.
    - Otherwise count; after ACK_TIMEOUT cycles without ack, set ack_err_o -> HOLDOFF.
  - WAIT_RELEASE: reset_active_i=0 -> HOLDOFF. No timeout.
  - HOLDOFF: count HOLDOFF_CYCLES cycles -> IDLE.
- Latency: a request visible in IDLE at edge k produces start_o high in the cycle following edge k.
- Button latency: btn_i must be stable about 2 + DEBOUNCE_CYCLES cycles before btn_req.
- Requests arriving in any non-IDLE state are discarded, never queued. A request on the same edge the FSM returns to IDLE is discarded.
- ack_err_o clears only on rst_n.
- cause_o holds until the next ISSUE.
- Reset mid-operation (rst_n low in any state): immediate return to IDLE with all outputs at reset values. No start pulse is generated on rst_n release.

Test Plan:
Use DEBOUNCE_CYCLES=4, WDT_LIMIT=20, ACK_TIMEOUT=16, HOLDOFF_CYCLES=8 with a behavioural sequencer model (reset_active_i high 2 cycles after start, for 20 cycles).
1. sw_req_i pulse at cycle 10 -> start_o high only at cycle 11; cause_o=10; req_count_o=1; busy_o high until HOLDOFF ends; back in IDLE 8 cycles after reset_active_i falls.
2. btn_i toggled every 2 cycles for 30 cycles, then held high -> no start_o during toggling; exactly one start_o about 6 cycles after stable high; cause_o=01; releasing button produces no pulse.
3. wdt_en_i=1, no kick -> start_o 21 cycles after enable, cause_o=11. Same with wdt_kick_i every 15 cycles -> no start_o over 200 cycles.
4. Button request and sw_req_i on the same IDLE edge -> one start_o, cause_o=01, req_count_o+1. sw_req_i during WAIT_RELEASE and HOLDOFF -> ignored.
5. Sequencer model disconnected (reset_active_i=0) -> start_o once, ack_err_o rises 16 cycles after WAIT_ASSERT entry, then HOLDOFF then IDLE; ack_err_o stays high until rst_n.
6. rst_n pulsed low during WAIT_RELEASE -> all outputs 0 immediately; no start_o after release. Then issue 256 sw requests -> req_count_o wraps to 0.
